// File: rtl/ahb_multi_nametable_ctrl.sv
// AHB-Lite slave for the multi-layer nametable RAMs. It also holds the per-layer scroll registers
// and runs a hardware block-fill engine that owns the shared RAM port while busy.
module ahb_multi_nametable_ctrl #(
    parameter int LAYERS = 2,
    parameter int RAM_AW = 9
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  HSEL,
    input  logic [31:0]           HADDR,
    input  logic [1:0]            HTRANS,
    input  logic [2:0]            HSIZE,
    input  logic                  HWRITE,
    input  logic [31:0]           HWDATA,
    input  logic                  HREADY,
    output logic                  HREADYOUT,
    output logic [31:0]           HRDATA,
    output logic [1:0]            HRESP,
    output logic [RAM_AW-1:0]     BRAM_ADDR,
    output logic [4*LAYERS-1:0]   BRAM_WE,
    output logic [31:0]           BRAM_WDATA,
    input  logic [32*LAYERS-1:0]  BRAM_RDATA,
    output logic [LAYERS-1:0]     scrollEn,
    output logic [LAYERS-1:0]     scrollPause,
    output logic [8*LAYERS-1:0]   scrollCntMax,
    output logic                  fill_done_irq
);

    // state | meaning
    // IDLE  | RAM port free for AHB traffic
    // FILL  | engine writes one word per cycle, AHB RAM data phases stalled
    typedef enum logic {IDLE, FILL} state_t;

    localparam logic [RAM_AW-1:0] OFF_START = RAM_AW'(8);
    localparam logic [RAM_AW-1:0] OFF_COUNT = RAM_AW'(9);
    localparam logic [RAM_AW-1:0] OFF_DATA  = RAM_AW'(10);
    localparam logic [RAM_AW-1:0] OFF_LAYER = RAM_AW'(11);
    localparam logic [RAM_AW-1:0] OFF_CTRL  = RAM_AW'(12);

    function automatic logic [3:0] byte_strb(input logic [1:0] off, input logic [1:0] size);
        case (size)
            2'd0:    return 4'b0001 << off;
            2'd1:    return (off == 2'd0) ? 4'h3 : ((off == 2'd2) ? 4'hC : 4'h0);
            2'd2:    return (off == 2'd0) ? 4'hF : 4'h0;
            default: return 4'h0;
        endcase
    endfunction

    state_t              state_q, state_d;
    logic                dp_valid, dp_reg, dp_write, rd_issued;
    logic [1:0]          dp_layer;
    logic [RAM_AW-1:0]   dp_word;
    logic [3:0]          dp_strb;
    logic [RAM_AW-1:0]   fill_start, f_addr;
    logic [RAM_AW:0]     fill_count, f_remain;
    logic [31:0]         fill_data, f_data;
    logic [1:0]          fill_layer, f_layer;
    logic                done;

    logic valid, ap_reg, busy, dp_ram, wr_commit, rd_pend, rd_ok, rd_reissue, ap_issue;
    logic reg_wr, reg_rd, go, clr_done, fill_load, fill_finish;
    logic [1:0]        ap_layer;
    logic [RAM_AW-1:0] ap_word;

    wire unused_bits = &{1'b0, HADDR[31:RAM_AW+5], HSIZE[2], HTRANS[0]};

    assign valid    = HSEL & HTRANS[1] & HREADY;
    assign ap_reg   = HADDR[RAM_AW+4];
    assign ap_layer = HADDR[RAM_AW+3:RAM_AW+2];
    assign ap_word  = HADDR[RAM_AW+1:2];

    assign busy       = (state_q == FILL);
    assign dp_ram     = dp_valid & ~dp_reg;
    assign wr_commit  = dp_ram & dp_write & ~busy;
    assign rd_pend    = dp_ram & ~dp_write;
    assign rd_ok      = rd_pend & rd_issued & ~busy;
    assign rd_reissue = rd_pend & ~rd_issued & ~busy;
    // A read address can only go out when neither the fill nor a committing write owns the port.
    assign ap_issue   = valid & ~ap_reg & ~HWRITE & ~busy & ~wr_commit;

    assign reg_wr   = dp_valid & dp_reg & dp_write;
    assign reg_rd   = dp_valid & dp_reg & ~dp_write;
    assign go       = reg_wr & (dp_word == OFF_CTRL) & HWDATA[0];
    assign clr_done = reg_wr & (dp_word == OFF_CTRL) & HWDATA[1];

    assign HREADYOUT = ~((dp_ram & dp_write & busy) | (rd_pend & ~rd_ok));
    assign HRESP     = 2'b00;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            dp_valid  <= 1'b0;
            dp_reg    <= 1'b0;
            dp_write  <= 1'b0;
            dp_layer  <= '0;
            dp_word   <= '0;
            dp_strb   <= '0;
            rd_issued <= 1'b0;
        end else if (HREADY) begin
            dp_valid  <= valid;
            dp_reg    <= ap_reg;
            dp_write  <= HWRITE;
            dp_layer  <= ap_layer;
            dp_word   <= ap_word;
            dp_strb   <= byte_strb(HADDR[1:0], HSIZE[1:0]);
            rd_issued <= ap_issue;
        end else if (rd_reissue) begin
            rd_issued <= 1'b1;
        end else if (busy) begin
            rd_issued <= 1'b0;
        end
    end

    always_comb begin
        BRAM_ADDR  = ap_word;
        BRAM_WE    = '0;
        BRAM_WDATA = HWDATA;
        if (busy) begin
            BRAM_ADDR  = f_addr;
            BRAM_WDATA = f_data;
            for (int l = 0; l < LAYERS; l++)
                if (f_layer == 2'(l)) BRAM_WE[4*l +: 4] = 4'hF;
        end else if (wr_commit || rd_reissue) begin
            BRAM_ADDR = dp_word;
            if (wr_commit)
                for (int l = 0; l < LAYERS; l++)
                    if (dp_layer == 2'(l)) BRAM_WE[4*l +: 4] = dp_strb;
        end
    end

    always_comb begin
        HRDATA = '0;
        if (rd_ok) begin
            for (int l = 0; l < LAYERS; l++)
                if (dp_layer == 2'(l)) HRDATA = BRAM_RDATA[32*l +: 32];
        end else if (reg_rd) begin
            for (int l = 0; l < LAYERS; l++)
                if (dp_word == RAM_AW'(l))
                    HRDATA = {16'b0, scrollCntMax[8*l +: 8], 6'b0, scrollPause[l], scrollEn[l]};
            case (dp_word)
                OFF_START: HRDATA = 32'(fill_start);
                OFF_COUNT: HRDATA = 32'(fill_count);
                OFF_DATA:  HRDATA = fill_data;
                OFF_LAYER: HRDATA = {30'b0, fill_layer};
                OFF_CTRL:  HRDATA = {30'b0, done, busy};
                default:   ;
            endcase
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            scrollEn     <= '0;
            scrollPause  <= '0;
            scrollCntMax <= '0;
            fill_start   <= '0;
            fill_count   <= '0;
            fill_data    <= '0;
            fill_layer   <= '0;
        end else if (reg_wr) begin
            for (int l = 0; l < LAYERS; l++)
                if (dp_word == RAM_AW'(l)) begin
                    scrollEn[l]           <= HWDATA[0];
                    scrollPause[l]        <= HWDATA[1];
                    scrollCntMax[8*l +: 8] <= HWDATA[15:8];
                end
            case (dp_word)
                OFF_START: fill_start <= HWDATA[RAM_AW-1:0];
                OFF_COUNT: fill_count <= HWDATA[RAM_AW:0];
                OFF_DATA:  fill_data  <= HWDATA;
                OFF_LAYER: fill_layer <= HWDATA[1:0];
                default:   ;
            endcase
        end
    end

    always_comb begin
        state_d     = state_q;
        fill_load   = 1'b0;
        fill_finish = 1'b0;
        case (state_q)
            IDLE: if (go) begin
                if (fill_count != '0) begin
                    state_d   = FILL;
                    fill_load = 1'b1;
                end else begin
                    fill_finish = 1'b1;
                end
            end
            FILL: if (f_remain == (RAM_AW+1)'(1)) begin
                state_d     = IDLE;
                fill_finish = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Fill parameters are snapshotted at go so register writes mid-fill cannot disturb it.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            f_addr        <= '0;
            f_remain      <= '0;
            f_data        <= '0;
            f_layer       <= '0;
            done          <= 1'b0;
            fill_done_irq <= 1'b0;
        end else begin
            fill_done_irq <= fill_finish;
            if (fill_load) begin
                f_addr   <= fill_start;
                f_remain <= fill_count;
                f_data   <= fill_data;
                f_layer  <= fill_layer;
            end else if (busy) begin
                f_addr   <= f_addr + 1'b1;
                f_remain <= f_remain - 1'b1;
            end
            if (fill_finish)   done <= 1'b1;
            else if (clr_done) done <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ahb_multi_nametable_ctrl.sv
// Directed bench for ahb_multi_nametable_ctrl: AHB access, strobes, port conflict, fill engine and reset.
module tb_ahb_multi_nametable_ctrl;
    localparam int LAYERS = 2;
    localparam int RAM_AW = 9;
    localparam logic [31:0] REG = 32'h2000;

    logic                 HCLK = 1'b0, HRESETn = 1'b0;
    logic                 HSEL, HWRITE, HREADY, HREADYOUT, fill_done_irq;
    logic [31:0]          HADDR, HWDATA, HRDATA, BRAM_WDATA;
    logic [1:0]           HTRANS, HRESP;
    logic [2:0]           HSIZE;
    logic [RAM_AW-1:0]    BRAM_ADDR;
    logic [4*LAYERS-1:0]  BRAM_WE;
    logic [32*LAYERS-1:0] BRAM_RDATA;
    logic [LAYERS-1:0]    scrollEn, scrollPause;
    logic [8*LAYERS-1:0]  scrollCntMax;

    ahb_multi_nametable_ctrl #(.LAYERS(LAYERS), .RAM_AW(RAM_AW)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
        .HSIZE(HSIZE), .HWRITE(HWRITE), .HWDATA(HWDATA), .HREADY(HREADY),
        .HREADYOUT(HREADYOUT), .HRDATA(HRDATA), .HRESP(HRESP), .BRAM_ADDR(BRAM_ADDR),
        .BRAM_WE(BRAM_WE), .BRAM_WDATA(BRAM_WDATA), .BRAM_RDATA(BRAM_RDATA),
        .scrollEn(scrollEn), .scrollPause(scrollPause), .scrollCntMax(scrollCntMax),
        .fill_done_irq(fill_done_irq)
    );

    always #5 HCLK = ~HCLK;
    assign HREADY = HREADYOUT;

    // Layer RAM model: synchronous read, byte-strobed write, cleared while in reset.
    logic [31:0] mem [LAYERS][512];
    logic [31:0] rd_q [LAYERS];
    always @(posedge HCLK) begin
        for (int l = 0; l < LAYERS; l++) begin
            if (!HRESETn) begin
                for (int a = 0; a < 512; a++) mem[l][a] <= '0;
                rd_q[l] <= '0;
            end else begin
                for (int b = 0; b < 4; b++)
                    if (BRAM_WE[4*l+b]) mem[l][BRAM_ADDR][8*b +: 8] <= BRAM_WDATA[8*b +: 8];
                rd_q[l] <= mem[l][BRAM_ADDR];
            end
        end
    end
    for (genvar g = 0; g < LAYERS; g++) begin : g_rd
        assign BRAM_RDATA[32*g +: 32] = rd_q[g];
    end

    int wr_cnt = 0, irq_cnt = 0;
    logic [8:0] log_addr [1024];
    logic [7:0] log_we   [1024];
    always @(negedge HCLK) begin
        if (BRAM_WE != '0 && wr_cnt < 1024) begin
            log_addr[wr_cnt] = BRAM_ADDR;
            log_we[wr_cnt]   = BRAM_WE;
            wr_cnt++;
        end
        if (fill_done_irq) irq_cnt++;
    end

    int n_chk = 0, n_fail = 0;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(output int waits);
        waits = 0;
        @(negedge HCLK);
        while (!HREADYOUT && waits < 50) begin
            waits++;
            @(negedge HCLK);
        end
    endtask

    task automatic ahb_write(input logic [31:0] a, input logic [31:0] d, input logic [2:0] sz,
                             output int waits, output logic [7:0] we, output logic [8:0] ba);
        HSEL = 1; HTRANS = 2'b10; HWRITE = 1; HADDR = a; HSIZE = sz;
        @(posedge HCLK); #1;
        HSEL = 0; HTRANS = 2'b00; HWRITE = 0; HWDATA = d;
        wait_done(waits);
        we = BRAM_WE; ba = BRAM_ADDR;
        @(posedge HCLK); #1;
    endtask

    task automatic ahb_read(input logic [31:0] a, output logic [31:0] d, output int waits);
        HSEL = 1; HTRANS = 2'b10; HWRITE = 0; HADDR = a; HSIZE = 3'd2;
        @(posedge HCLK); #1;
        HSEL = 0; HTRANS = 2'b00;
        wait_done(waits);
        d = HRDATA;
        @(posedge HCLK); #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        int w; logic [7:0] we; logic [8:0] ba;
        ahb_write(a, d, 3'd2, w, we, ba);
    endtask

    int w, base, ib;
    logic [7:0] we;
    logic [8:0] ba;
    logic [31:0] d;

    initial begin
        HSEL = 0; HTRANS = 0; HWRITE = 0; HADDR = 0; HSIZE = 0; HWDATA = 0;
        repeat (3) @(posedge HCLK);
        #1;
        chk("rst_readyout", 32'(HREADYOUT), 1);
        chk("rst_we", 32'(BRAM_WE), 0);
        chk("rst_irq", 32'(fill_done_irq), 0);
        chk("rst_scroll", 32'({scrollEn, scrollPause, scrollCntMax}), 0);
        chk("rst_hresp", 32'(HRESP), 0);
        HRESETn = 1;
        @(posedge HCLK); #1;
        ahb_read(REG + 12*4, d, w);
        chk("rst_fill_ctrl", d, 0);

        ahb_write(32'h814, 32'h11223344, 3'd2, w, we, ba);
        chk("wr_we", 32'(we), 32'hF0);
        chk("wr_addr", 32'(ba), 5);
        chk("wr_waits", w, 0);
        ahb_read(32'h814, d, w);
        chk("rd_data", d, 32'h11223344);
        chk("rd_waits", w, 0);

        // Byte write to word 7 lane 2, read issued in the write's data phase.
        HSEL = 1; HTRANS = 2'b10; HWRITE = 1; HADDR = 32'h1E; HSIZE = 3'd0;
        @(posedge HCLK); #1;
        HWDATA = 32'h00AB0000; HWRITE = 0; HADDR = 32'h1C; HSIZE = 3'd2;
        @(negedge HCLK);
        chk("conf_we", 32'(BRAM_WE), 32'h04);
        @(posedge HCLK); #1;
        HSEL = 0; HTRANS = 2'b00;
        wait_done(w);
        chk("conf_data", HRDATA, 32'h00AB0000);
        chk("conf_waits", w, 1);
        @(posedge HCLK); #1;

        ahb_write(32'h52, 32'hBEEF0000, 3'd1, w, we, ba);
        chk("half_we", 32'(we), 32'h0C);
        ahb_read(32'h50, d, w);
        chk("half_data", d, 32'hBEEF0000);
        ahb_write(32'h55, 32'hDEADBEEF, 3'd2, w, we, ba);
        chk("misalign_we", 32'(we), 0);
        ahb_read(32'h54, d, w);
        chk("misalign_data", d, 0);
        ahb_write(32'h1014, 32'hCAFEF00D, 3'd2, w, we, ba);
        chk("badlayer_we", 32'(we), 0);
        ahb_read(32'h1014, d, w);
        chk("badlayer_data", d, 0);

        // Fill 510..1 on layer 0, with a RAM read of word 510 right behind the go.
        wr(REG + 8*4, 510); wr(REG + 9*4, 4); wr(REG + 10*4, 32'hA5A5A5A5); wr(REG + 11*4, 0);
        base = wr_cnt; ib = irq_cnt;
        HSEL = 1; HTRANS = 2'b10; HWRITE = 1; HADDR = REG + 12*4; HSIZE = 3'd2;
        @(posedge HCLK); #1;
        HWDATA = 32'h1; HWRITE = 0; HADDR = 32'h7F8;
        @(posedge HCLK); #1;
        HSEL = 0; HTRANS = 2'b00;
        wait_done(w);
        chk("fillrd_data", HRDATA, 32'hA5A5A5A5);
        chk("fillrd_waits", w, 5);
        @(posedge HCLK); #1;
        repeat (4) @(posedge HCLK); #1;
        chk("fill1_nwr", wr_cnt - base, 4);
        chk("fill1_a0", 32'(log_addr[base]), 510);
        chk("fill1_a1", 32'(log_addr[base+1]), 511);
        chk("fill1_a2", 32'(log_addr[base+2]), 0);
        chk("fill1_a3", 32'(log_addr[base+3]), 1);
        chk("fill1_we", 32'(log_we[base+3]), 32'h0F);
        chk("fill1_irq", irq_cnt - ib, 1);
        ahb_read(REG + 12*4, d, w);
        chk("fill1_ctrl", d, 2);
        ahb_read(32'h4, d, w);
        chk("fill1_word1", d, 32'hA5A5A5A5);
        ahb_read(32'h8, d, w);
        chk("fill1_word2", d, 0);

        // Fill on layer 1 with register traffic while it runs.
        wr(REG + 8*4, 100); wr(REG + 9*4, 6); wr(REG + 10*4, 32'h12345678); wr(REG + 11*4, 1);
        base = wr_cnt;
        wr(REG + 12*4, 3);
        ahb_write(REG + 1*4, 32'h00002003, 3'd2, w, we, ba);
        chk("ctrl_wr_waits", w, 0);
        ahb_write(REG + 10*4, 32'h0, 3'd2, w, we, ba);
        chk("data_wr_waits", w, 0);
        ahb_read(REG + 12*4, d, w);
        chk("busy_ctrl", d, 1);
        chk("busy_rd_waits", w, 0);
        repeat (4) @(posedge HCLK); #1;
        chk("scroll_en", 32'(scrollEn), 32'h2);
        chk("scroll_pause", 32'(scrollPause), 32'h2);
        chk("scroll_max", 32'(scrollCntMax), 32'h2000);
        chk("fill2_nwr", wr_cnt - base, 6);
        ahb_read(32'h990, d, w);
        chk("fill2_first", d, 32'h12345678);
        ahb_read(32'h9A4, d, w);
        chk("fill2_last", d, 32'h12345678);
        ahb_read(32'h9A8, d, w);
        chk("fill2_after", d, 0);

        wr(REG + 9*4, 0);
        wr(REG + 12*4, 2);
        ahb_read(REG + 12*4, d, w);
        chk("done_cleared", d, 0);
        base = wr_cnt; ib = irq_cnt;
        wr(REG + 12*4, 1);
        repeat (3) @(posedge HCLK); #1;
        chk("zero_irq", irq_cnt - ib, 1);
        chk("zero_nwr", wr_cnt - base, 0);
        ahb_read(REG + 12*4, d, w);
        chk("zero_ctrl", d, 2);

        wr(REG + 8*4, 0); wr(REG + 9*4, 100); wr(REG + 11*4, 1);
        wr(REG + 12*4, 1);
        repeat (3) @(posedge HCLK); #1;
        HRESETn = 0;
        #1;
        chk("midrst_we", 32'(BRAM_WE), 0);
        chk("midrst_ready", 32'(HREADYOUT), 1);
        chk("midrst_scroll", 32'({scrollEn, scrollPause, scrollCntMax}), 0);
        base = wr_cnt;
        repeat (3) @(posedge HCLK); #1;
        HRESETn = 1;
        repeat (20) @(posedge HCLK); #1;
        chk("midrst_nwr", wr_cnt - base, 0);
        ahb_read(REG + 12*4, d, w);
        chk("midrst_ctrl", d, 0);
        ahb_read(REG + 9*4, d, w);
        chk("midrst_count", d, 0);
        chk("hresp", 32'(HRESP), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
